// File: rtl/clock_group_reset_sequencer.sv
// Staggered per-member reset sequencer for a clock group: hold all targets, then release in ascending order.
// Optional status outputs when CLOCK_GROUP_RESET_SEQ_STATUS_EN is defined.
module clock_group_reset_sequencer #(
  parameter int NUM_MEMBERS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  localparam int MAX_CYCLES    = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES,
  localparam int CNT_W         = $clog2(MAX_CYCLES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [NUM_MEMBERS-1:0] auto_out_member_reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NUM_MEMBERS-1:0] req_mask,
  output logic                   done
`ifdef CLOCK_GROUP_RESET_SEQ_STATUS_EN
  ,
  output logic [1:0]             status_state,
  output logic [CNT_W-1:0]       status_count
`endif
);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_MEMBERS-1:0] memberRst;
  logic [NUM_MEMBERS-1:0] targetMask;
  logic [NUM_MEMBERS-1:0] pending;
  logic [NUM_MEMBERS-1:0] pendingNext;
  logic                   lastPending;
  logic                   releaseEdge;

  // Clearing the lowest set bit keeps releases ascending and skips non-targets for free.
  always_comb begin
    pending     = memberRst & targetMask;
    pendingNext = pending & (pending - NUM_MEMBERS'(1));
    lastPending = (pendingNext == '0);
    releaseEdge = 1'b0;
    case (state)
      HOLD:    releaseEdge = (cnt == HOLD_LAST);
      RELEASE: releaseEdge = (cnt == STAGGER_LAST);
      default: releaseEdge = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HOLD;
      cnt        <= '0;
      memberRst  <= '1;
      targetMask <= '1;
      req_ready  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        HOLD, RELEASE: begin
          if (releaseEdge) begin
            cnt       <= '0;
            memberRst <= pendingNext;
            if (lastPending) begin
              state     <= RUN;
              done      <= 1'b1;
              req_ready <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          // An all-zero mask completes the handshake but changes nothing.
          if (req_valid && req_ready && (req_mask != '0)) begin
            state      <= HOLD;
            cnt        <= '0;
            memberRst  <= req_mask;
            targetMask <= req_mask;
            req_ready  <= 1'b0;
            done       <= 1'b0;
          end
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign auto_out_member_reset = memberRst;

`ifdef CLOCK_GROUP_RESET_SEQ_STATUS_EN
  assign status_state = state;
  assign status_count = cnt;
`endif

endmodule

// File: doc/clock_group_reset_sequencer.md
CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

Interface
REQ-001 Parameter NUM_MEMBERS, default 4: number of clock-group members driven (1..16).
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all targeted resets are held asserted (>=1).
REQ-003 Parameter STAGGER_CYCLES, default 4: cycles between successive member deassertions (>=1).
REQ-004 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port auto_out_member_reset, output, NUM_MEMBERS: per-member reset driven into the clock-group aggregator input; bit i = member i, 1 = in reset.
REQ-007 Port req_valid, input, 1: request to re-sequence a subset of members.
REQ-008 Port req_ready, output, 1: sequencer can accept a request.
REQ-009 Port req_mask, input, NUM_MEMBERS: members to re-sequence; sampled on handshake.
REQ-010 Port done, output, 1: all members out of reset and sequencer idle.

Function
REQ-011 Outputs SHALL be registered, with no combinational path from any input to any output.
REQ-012 States SHALL be HOLD, RELEASE and RUN, plus an internal NUM_MEMBERS-bit target mask.
REQ-013 HOLD: all target bits asserted; counter counts up to HOLD_CYCLES; on the HOLD_CYCLES-th edge the lowest-index target member deasserts and the state goes to RELEASE.
REQ-014 RELEASE: every STAGGER_CYCLES edges, the next-higher-index target member deasserts; members not in the target mask are skipped with no stagger delay charged.
REQ-015 On the edge that deasserts the last target member, state goes to RUN, with done=1 and req_ready=1 on that same edge.
REQ-016 A single-member target SHALL go directly from HOLD to RUN on the HOLD_CYCLES-th edge.
REQ-017 A handshake SHALL occur only when req_valid=1 and req_ready=1 are sampled on the same edge; req_valid while req_ready=0 is ignored and not queued.
REQ-018 Handshake with req_mask nonzero: on the next edge, masked bits are asserted, target mask = req_mask, state goes to HOLD, counter is cleared, and done and req_ready go to 0.
REQ-019 Unmasked members SHALL remain deasserted throughout the sequence.
REQ-020 Handshake with req_mask all-zero SHALL be accepted with no effect: the block stays in RUN with done=1 and req_ready=1.
REQ-021 Counter width SHALL be clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1); the counter SHALL never wrap within a state.
REQ-022 Deassertion order SHALL always be ascending index; no two members deassert on the same edge.

Reset
REQ-023 While reset=1: auto_out_member_reset = all ones, state = HOLD, target mask = all ones, counter = 0, req_ready = 0, done = 0.
REQ-024 Reset asserted mid-sequence or in RUN SHALL abort immediately on that edge and restart the full all-member sequence once reset falls.
REQ-025 The first HOLD count SHALL begin on the first edge with reset=0.

Configuration
REQ-026 Macro CLOCK_GROUP_RESET_SEQ_STATUS_EN.
- Defined: adds output status_state [1:0] (HOLD=0, RELEASE=1, RUN=2) and output status_count (counter width, current counter value), both registered and reset to 0.
- Undefined: these ports are absent and function is identical.

Verification
REQ-027 Defaults; reset high for 3 cycles then low. Required: outputs = 4'b1111 during reset; bits 0/1/2/3 clear at edges 16/20/24/28 after reset falls; done=1 and req_ready=1 at edge 28.
REQ-028 In RUN, req_valid=1 with req_mask=4'b1010 for one cycle. Required: next edge outputs = 4'b1010, done=0; bit1 clears 16 edges later; bit3 clears 4 edges after that; bits 0/2 stay 0 throughout.
REQ-029 In RUN, handshake with req_mask=0. Required: outputs stay 4'b0000; done and req_ready stay 1.
REQ-030 req_valid=1, req_mask=4'b0001 held during RELEASE. Required: request ignored, sequence timing unchanged, request accepted on first edge with req_ready=1.
REQ-031 Reset pulsed 1 cycle at edge 22 of initial sequence. Required: outputs = 4'b1111 on that edge; full 16/20/24/28 sequence restarts from reset fall.
REQ-032 NUM_MEMBERS=1, HOLD_CYCLES=1. Required: bit0 clears and done=1 on the first edge after reset falls.
